// File: rtl/serial_io_bus_bridge_pkg.sv
// Shared types and constants for the Avalon-to-UART serial IO bridge.
package serial_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  localparam logic [15:0] UART_WINDOW_BASE      = 16'h0200;
  localparam int unsigned UART_WINDOW_MASK_BITS = 6;

  localparam int unsigned DEF_SETUP_CYCLES  = 2;
  localparam int unsigned DEF_STROBE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES   = 1;

  // True when the byte offset falls inside the 64-byte UART window.
  function automatic logic in_uart_window(input logic [15:0] addr);
    return addr[15:UART_WINDOW_MASK_BITS] == UART_WINDOW_BASE[15:UART_WINDOW_MASK_BITS];
  endfunction

endpackage

// File: rtl/serial_io_bus_bridge.sv
// Converts single Avalon-MM accesses into timed setup/strobe/hold cycles on
// the byte-wide 16550 UART bus, stalling the master until the cycle is done.
module serial_io_bus_bridge
  import serial_io_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] AvsAddress,
  input  logic        AvsRead,
  input  logic        AvsWrite,
  input  logic [1:0]  AvsByteEnable,
  input  logic [15:0] AvsWriteData,
  output logic [15:0] AvsReadData,
  output logic        AvsWaitRequest,
  output logic [15:0] Address,
  output logic        IOSelect_H,
  output logic        ByteSelect_L,
  output logic        UartRead_H,
  output logic        UartWrite_H,
  output logic [7:0]  UartDataOut,
  input  logic [7:0]  UartDataIn
);

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] count;
  logic       is_write;
  logic       req;
  logic       valid;
  logic       bus_next;
  logic       strobe_next;
  logic       unused_bits;

  assign req            = AvsRead | AvsWrite;
  assign valid          = in_uart_window(AvsAddress) && AvsByteEnable[1];
  assign AvsWaitRequest = req && (state != DONE) && !Reset;
  assign unused_bits    = ^{AvsWriteData[7:0], AvsByteEnable[0]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = valid ? SETUP : DONE;
      SETUP:   if (count == SETUP_LAST) next_state = STROBE;
      STROBE:  if (count == STROBE_LAST) next_state = HOLD;
      HOLD:    if (count == HOLD_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are registered from next_state so they line up with the phase.
  assign bus_next    = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
  assign strobe_next = (next_state == STROBE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count        <= '0;
      is_write     <= 1'b0;
      Address      <= '0;
      IOSelect_H   <= 1'b0;
      ByteSelect_L <= 1'b1;
      UartRead_H   <= 1'b0;
      UartWrite_H  <= 1'b0;
      UartDataOut  <= '0;
      AvsReadData  <= '0;
    end else begin
      if (state != next_state || state == IDLE || state == DONE) count <= '0;
      else                                                       count <= count + 4'd1;

      IOSelect_H   <= bus_next;
      ByteSelect_L <= !bus_next;
      UartWrite_H  <= strobe_next && is_write;
      UartRead_H   <= strobe_next && !is_write;

      if (state == IDLE && req) begin
        is_write <= AvsWrite;
        if (valid) begin
          Address <= AvsAddress;
          if (AvsWrite) UartDataOut <= AvsWriteData[15:8];
        end else if (!AvsWrite) begin
          AvsReadData <= '0;
        end
      end

      if (state == STROBE && next_state == HOLD && !is_write)
        AvsReadData <= {UartDataIn, 8'h00};
    end
  end

endmodule

// File: tb/tb_serial_io_bus_bridge.sv
// Bench for serial_io_bus_bridge: a timeline model per instance checked every
// cycle, plus directed transactions with literal latency/data expectations.
module tb_serial_io_bus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] i_addr  [2];
  logic        i_rd    [2];
  logic        i_wr    [2];
  logic [1:0]  i_be    [2];
  logic [15:0] i_wdata [2];
  logic [7:0]  i_din   [2];
  logic [15:0] o_rdata [2];
  logic        o_wait  [2];
  logic [15:0] o_addr  [2];
  logic        o_iosel [2];
  logic        o_bsel  [2];
  logic        o_urd   [2];
  logic        o_uwr   [2];
  logic [7:0]  o_dout  [2];

  int checks = 0;
  int failures = 0;

  serial_io_bus_bridge dut_a (
    .Clock(clk), .Reset(rst),
    .AvsAddress(i_addr[0]), .AvsRead(i_rd[0]), .AvsWrite(i_wr[0]),
    .AvsByteEnable(i_be[0]), .AvsWriteData(i_wdata[0]),
    .AvsReadData(o_rdata[0]), .AvsWaitRequest(o_wait[0]),
    .Address(o_addr[0]), .IOSelect_H(o_iosel[0]), .ByteSelect_L(o_bsel[0]),
    .UartRead_H(o_urd[0]), .UartWrite_H(o_uwr[0]),
    .UartDataOut(o_dout[0]), .UartDataIn(i_din[0])
  );

  serial_io_bus_bridge #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut_b (
    .Clock(clk), .Reset(rst),
    .AvsAddress(i_addr[1]), .AvsRead(i_rd[1]), .AvsWrite(i_wr[1]),
    .AvsByteEnable(i_be[1]), .AvsWriteData(i_wdata[1]),
    .AvsReadData(o_rdata[1]), .AvsWaitRequest(o_wait[1]),
    .Address(o_addr[1]), .IOSelect_H(o_iosel[1]), .ByteSelect_L(o_bsel[1]),
    .UartRead_H(o_urd[1]), .UartWrite_H(o_uwr[1]),
    .UartDataOut(o_dout[1]), .UartDataIn(i_din[1])
  );

  localparam int SP[2] = '{2, 1};
  localparam int PP[2] = '{4, 1};
  localparam int HP[2] = '{1, 1};

  bit          m_act  [2];
  int          m_k    [2];
  bit          m_val  [2];
  bit          m_wr   [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_wb   [2];
  logic [15:0] m_rdat [2];
  int          wcnt   [2];
  int          rcnt   [2];

  task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Timeline model: k counts cycles since the request was first seen idle.
  task automatic cmp(input int d);
    int s, p, h, dn;
    bit req, iosel, strobe;
    s = SP[d]; p = PP[d]; h = HP[d];
    req = i_rd[d] | i_wr[d];
    if (rst) begin
      m_act[d] = 0;
      m_rdat[d] = '0;
      chk("rst_wait",  d, 16'(o_wait[d]),  16'(0));
      chk("rst_iosel", d, 16'(o_iosel[d]), 16'(0));
      chk("rst_bsel",  d, 16'(o_bsel[d]),  16'(1));
      chk("rst_urd",   d, 16'(o_urd[d]),   16'(0));
      chk("rst_uwr",   d, 16'(o_uwr[d]),   16'(0));
      chk("rst_addr",  d, o_addr[d],       16'h0000);
      chk("rst_dout",  d, 16'(o_dout[d]),  16'(0));
      chk("rst_rdata", d, o_rdata[d],      16'h0000);
      return;
    end
    if (!m_act[d] && req) begin
      m_act[d]  = 1;
      m_k[d]    = 0;
      m_wr[d]   = i_wr[d];
      m_val[d]  = ((i_addr[d] >> 6) == 16'h0008) && i_be[d][1];
      m_addr[d] = i_addr[d];
      m_wb[d]   = i_wdata[d][15:8];
    end
    dn     = m_val[d] ? 1 + s + p + h : 1;
    iosel  = m_act[d] && m_val[d] && m_k[d] >= 1 && m_k[d] <= s + p + h;
    strobe = m_act[d] && m_val[d] && m_k[d] >= s + 1 && m_k[d] <= s + p;
    chk("wait",  d, 16'(o_wait[d]),  16'(req && !(m_act[d] && m_k[d] == dn)));
    chk("iosel", d, 16'(o_iosel[d]), 16'(iosel));
    chk("bsel",  d, 16'(o_bsel[d]),  16'(!iosel));
    chk("uwr",   d, 16'(o_uwr[d]),   16'(strobe && m_wr[d]));
    chk("urd",   d, 16'(o_urd[d]),   16'(strobe && !m_wr[d]));
    chk("rdata", d, o_rdata[d],      m_rdat[d]);
    if (iosel) chk("addr", d, o_addr[d], m_addr[d]);
    if (iosel && m_wr[d]) chk("dout", d, 16'(o_dout[d]), 16'(m_wb[d]));
    if (m_act[d]) begin
      if (m_val[d] && !m_wr[d] && m_k[d] == s + p) m_rdat[d] = {i_din[d], 8'h00};
      if (!m_val[d] && !m_wr[d] && m_k[d] == 0) m_rdat[d] = '0;
      if (m_k[d] == dn) m_act[d] = 0;
      else m_k[d] = m_k[d] + 1;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      cmp(d);
      if (o_uwr[d]) wcnt[d]++;
      if (o_urd[d]) rcnt[d]++;
    end
  end

  task automatic run_txn(input int d, input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wdata, input logic [7:0] din,
                         input int exp_lat, input logic [15:0] exp_rdata,
                         input int exp_w, input int exp_r, input logic [7:0] exp_dout);
    int lat;
    bit done;
    logic [15:0] snap_addr;
    logic [7:0] snap_dout;
    @(posedge clk); #1;
    i_rd[d] = rd; i_wr[d] = wr; i_addr[d] = addr; i_be[d] = be;
    i_wdata[d] = wdata; i_din[d] = din;
    wcnt[d] = 0; rcnt[d] = 0;
    lat = 0; done = 0;
    snap_addr = '0; snap_dout = '0;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (lat == 5) begin snap_addr = o_addr[d]; snap_dout = o_dout[d]; end
      if (!o_wait[d]) done = 1;
      else lat++;
    end
    chk("latency", d, 16'(lat), 16'(exp_lat));
    @(posedge clk); #1;
    i_rd[d] = 0; i_wr[d] = 0;
    chk("rdata_final", d, o_rdata[d], exp_rdata);
    chk("wr_strobes", d, 16'(wcnt[d]), 16'(exp_w));
    chk("rd_strobes", d, 16'(rcnt[d]), 16'(exp_r));
    if (exp_lat > 5) chk("mid_addr", d, snap_addr, addr);
    if (exp_lat > 5 && wr) chk("mid_dout", d, 16'(snap_dout), 16'(exp_dout));
  endtask

  logic [7:0] b2b_bytes [3] = '{8'h11, 8'hC3, 8'h7E};

  initial begin
    for (int d = 0; d < 2; d++) begin
      i_addr[d] = '0; i_rd[d] = 0; i_wr[d] = 0; i_be[d] = '0;
      i_wdata[d] = '0; i_din[d] = '0; wcnt[d] = 0; rcnt[d] = 0;
      m_act[d] = 0; m_k[d] = 0; m_rdat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);

    run_txn(0, 0, 1, 16'h0200, 2'b11, 16'hAB55, 8'h00, 8, 16'h0000, 4, 0, 8'hAB);
    run_txn(0, 1, 0, 16'h0214, 2'b11, 16'h0000, 8'h5A, 8, 16'h5A00, 0, 4, 8'h00);
    run_txn(0, 1, 0, 16'h0300, 2'b11, 16'h0000, 8'hFF, 1, 16'h0000, 0, 0, 8'h00);
    run_txn(0, 1, 0, 16'h0200, 2'b01, 16'h0000, 8'hFF, 1, 16'h0000, 0, 0, 8'h00);
    run_txn(0, 1, 0, 16'h023F, 2'b10, 16'h0000, 8'h96, 8, 16'h9600, 0, 4, 8'h00);
    run_txn(0, 1, 1, 16'h0230, 2'b11, 16'h3CAA, 8'hEE, 8, 16'h9600, 4, 0, 8'h3C);

    // Reset lands in cycle 4 of a write, while the write strobe is high.
    @(posedge clk); #1;
    i_wr[0] = 1; i_addr[0] = 16'h0200; i_be[0] = 2'b11; i_wdata[0] = 16'h1234;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_mid_uwr",   0, 16'(o_uwr[0]),   16'(0));
    chk("rst_mid_iosel", 0, 16'(o_iosel[0]), 16'(0));
    chk("rst_mid_wait",  0, 16'(o_wait[0]),  16'(0));
    @(posedge clk); #1 i_wr[0] = 0;
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    run_txn(0, 1, 0, 16'h0220, 2'b11, 16'h0000, 8'hC7, 8, 16'hC700, 0, 4, 8'h00);

    // Back-to-back reads held high on the short-timing instance.
    @(posedge clk); #1;
    i_rd[1] = 1; i_addr[1] = 16'h0204; i_be[1] = 2'b10; i_din[1] = b2b_bytes[0];
    for (int t = 0; t < 3; t++) begin
      int lat;
      bit done;
      lat = 0; done = 0;
      while (!done && lat < 40) begin
        @(negedge clk);
        if (!o_wait[1]) done = 1;
        else lat++;
      end
      chk("b2b_latency", 1, 16'(lat), 16'(4));
      chk("b2b_rdata", 1, o_rdata[1], {b2b_bytes[t], 8'h00});
      @(posedge clk); #1;
      if (t < 2) i_din[1] = b2b_bytes[t + 1];
      else i_rd[1] = 0;
    end
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_io_bus_bridge.md
Name: serial_io_bus_bridge

Overview:
Bridges the HPS lightweight Avalon-MM slave window (0xFF21_0000–0xFF21_FFFF) onto the byte-wide 16550 UART bus that feeds the serial IO address decoder. Converts each single Avalon read/write into a timed UART bus cycle with setup, strobe and hold phases, and stalls the master with waitrequest until the cycle completes. Drives Address/IOSelect_H/ByteSelect_L into the decoder, drives RD/WR strobes and write data to the UART chips, and returns UART read data on D15–D8.

Parameters:
SETUP_CYCLES, 2, cycles address/select are stable before strobe (1..15)
STROBE_CYCLES, 4, cycles RD/WR strobe is asserted (1..15)
HOLD_CYCLES, 1, cycles address/select stay stable after strobe (1..15)

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous reset, active high
AvsAddress  in  16  byte offset within the 0xFF21_xxxx window
AvsRead  in  1  Avalon read request
AvsWrite  in  1  Avalon write request
AvsByteEnable  in  2  [1]=D15–D8, [0]=D7–D0
AvsWriteData  in  16  write data; UART byte on [15:8]
AvsReadData  out  16  read data; UART byte on [15:8], [7:0]=0
AvsWaitRequest  out  1  stall master while access in progress
Address  out  16  registered address to decoder
IOSelect_H  out  1  bus cycle active, to decoder
ByteSelect_L  out  1  low = upper-byte access, to decoder
UartRead_H  out  1  read strobe to UART chips
UartWrite_H  out  1  write strobe to UART chips
UartDataOut  out  8  write byte to UART chips
UartDataIn  in  8  read byte from UART chips

Behaviour:
- Reset (async): state IDLE, counter 0; Address=0, IOSelect_H=0, ByteSelect_L=1, UartRead_H=0, UartWrite_H=0, UartDataOut=0, AvsReadData=0. AvsWaitRequest=0 while Reset is high.
- AvsWaitRequest = (AvsRead | AvsWrite) & (state != DONE). Combinational; all other outputs registered.
- Valid access: AvsAddress[15:6]==10'h008 (0x0200–0x023F) and AvsByteEnable[1]==1.
- States: IDLE, SETUP, STROBE, HOLD, DONE; 4-bit phase counter.
- IDLE: on AvsRead|AvsWrite, capture address, direction (write wins if both asserted), and AvsWriteData[15:8]. Valid access -> SETUP. Invalid access -> DONE directly, no strobes, AvsReadData=0.
- SETUP: Address=captured, IOSelect_H=1, ByteSelect_L=0, UartDataOut=captured byte (writes). After SETUP_CYCLES cycles -> STROBE.
- STROBE: UartRead_H or UartWrite_H =1 per direction. On the last STROBE cycle, read latches AvsReadData={UartDataIn,8'h00}. After STROBE_CYCLES cycles -> HOLD.
- HOLD: strobes 0; Address/IOSelect_H/ByteSelect_L/UartDataOut held. After HOLD_CYCLES -> DONE.
- DONE: IOSelect_H=0, ByteSelect_L=1, waitrequest low for exactly one cycle (transfer completes). Next state IDLE.
- Latency: request first seen in IDLE at cycle 0. Strobe covers cycles 1+S .. S+P. DONE at cycle 1+S+P+H. Defaults: strobe cycles 3–6, DONE at cycle 8. Invalid access completes at cycle 1.
- Back-to-back: request held high after DONE is treated as a new transaction from IDLE (one idle cycle minimum between bus cycles).
- AvsReadData holds its last value until the next read latch or invalid read. Writes do not modify it.
- Request dropped mid-cycle (protocol violation): cycle runs to DONE regardless; strobe is never truncated.
- Reset mid-operation: strobes and IOSelect_H drop immediately (async); FSM returns to IDLE.
- Strobes are never asserted while IOSelect_H=0, and UartRead_H and UartWrite_H are never both high.

Decomposition:
- Package serial_io_pkg: state enum; window constants UART_WINDOW_BASE=16'h0200 and UART_WINDOW_MASK_BITS=6; default timing constants.
- No sub-module; a flat FSM with one counter is sufficient.

Test Plan:
- Write 0xAB55 to offset 0x0200, BE=2'b11, defaults -> UartWrite_H high cycles 3–6; UartDataOut=0xAB; IOSelect_H=1, ByteSelect_L=0, Address=0x0200 over cycles 1–7; waitrequest low at cycle 8 only.
- Read offset 0x0214 with UartDataIn=0x5A -> UartRead_H high cycles 3–6; AvsReadData=0x5A00 at cycle 8.
- Read 0x0300, then read 0x0200 with BE=2'b01 -> each completes at cycle 1; no IOSelect_H or strobes; AvsReadData=0x0000.
- AvsRead=AvsWrite=1 at 0x0230 -> write cycle only; UartRead_H never asserted.
- Assert Reset at cycle 4 of a write -> UartWrite_H, IOSelect_H and AvsWaitRequest fall in the same cycle; after release, a new read at 0x0220 completes normally at cycle 8.
- SETUP=1, STROBE=1, HOLD=1 with back-to-back reads held high -> each completes at cycle 4, one IDLE cycle between transactions, and each returns correct data.
